dmem_access_ctrl: RTL

Sequencing controller and two-port arbiter in front of the word-organised data memory (1024 × 32 bit, combinational read, write on CLK rising edge). It shares the memory between the CPU load/store path and a program/debug loader port. It turns CPU byte loads (lb/lbu) into word reads with lane select and extension. It turns byte stores (sb) into a two-cycle read-modify-write, so the memory itself only ever sees aligned word accesses.

---
 rtl/dmem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequencer + two-port arbiter in front of a word data memory.
// Byte loads become word reads with lane select/extension; byte stores become
// a read-modify-write so the memory only ever sees aligned word accesses.
// Ports:
//   CLK, Reset              clock, synchronous active-high reset
//   c_req/c_we/c_byte/c_sext/c_adr/c_wdata -> c_ack/c_rdata   CPU port
//   l_req/l_we/l_adr/l_wdata -> l_ack/l_rdata                  loader port
//   m_adr/m_we/m_wdata -> m_rdata                              memory side
//   busy (state != IDLE), grant (0 = CPU, 1 = loader)
// Optional feature: define DMEM_ACCESS_LOADER_EN to build the loader port and
// its starvation counter; otherwise the loader inputs are ignored.
module dmem_access_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_byte,
    input  logic              c_sext,
    input  logic [31:0]       c_adr,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_adr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
    output logic [31:0]       l_rdata,
    output logic [ADDR_W-1:0] m_adr,
    output logic              m_we,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_we;
    logic              r_byte;
    logic              r_sext;
    logic [1:0]        r_lane;
    logic [7:0]        r_bdata;
    logic [ADDR_W-1:0] r_madr;
    logic [31:0]       r_mwdata;
    logic [31:0]       r_c_rdata;

    logic              w_any;
    logic              w_sel_l;
    logic              w_own_l;
    logic              w_req_we;
    logic [31:0]       w_req_adr;
    logic [31:0]       w_req_wdata;
    logic              w_rmw;
    logic              w_m_we;
    logic [7:0]        w_lane_byte;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;
    logic              w_unused;

`ifdef DMEM_ACCESS_LOADER_EN
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_starve;
    logic          r_grant;
    logic [31:0]   r_l_rdata;

    // Loader wins only when alone, or once the CPU has had its quota.
    assign w_sel_l     = l_req && (!c_req || (r_starve == CW'(STARVE_MAX)));
    assign w_any       = c_req || l_req;
    assign w_own_l     = r_grant;
    assign w_req_we    = w_sel_l ? l_we : c_we;
    assign w_req_adr   = w_sel_l ? l_adr : c_adr;
    assign w_req_wdata = w_sel_l ? l_wdata : c_wdata;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_starve  <= '0;
            r_grant   <= 1'b0;
            r_l_rdata <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (!l_req || w_sel_l) begin
                    r_starve <= '0;
                end else if (c_req && (r_starve != CW'(STARVE_MAX))) begin
                    r_starve <= r_starve + CW'(1);
                end
                if (w_any) begin
                    r_grant <= w_sel_l;
                end
            end
            if ((r_state == ACCESS) && r_grant && !r_we) begin
                r_l_rdata <= m_rdata;
            end
        end
    end

    assign grant   = r_grant;
    assign l_rdata = r_l_rdata;
    assign l_ack   = (r_state == RESP) && r_grant && !Reset;
`else
    logic w_unused_ld;

    assign w_sel_l     = 1'b0;
    assign w_any       = c_req;
    assign w_own_l     = 1'b0;
    assign w_req_we    = c_we;
    assign w_req_adr   = c_adr;
    assign w_req_wdata = c_wdata;
    assign grant       = 1'b0;
    assign l_rdata     = '0;
    assign l_ack       = 1'b0;
    assign w_unused_ld = ^{l_req, l_we, l_adr, l_wdata};
`endif

    assign w_rmw = !w_sel_l && c_we && c_byte;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_we      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_rmw ? RMW_RD : ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
                w_m_we      = r_we;
            end
            RMW_RD: begin
                w_state_nxt = RMW_WR;
            end
            RMW_WR: begin
                w_state_nxt = RESP;
                w_m_we      = 1'b1;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Lane extraction for byte loads and lane merge for byte stores.
    always_comb begin
        w_lane_byte = m_rdata[7:0];
        w_merged    = m_rdata;
        unique case (r_lane)
            2'd0: begin
                w_lane_byte   = m_rdata[7:0];
                w_merged[7:0] = r_bdata;
            end
            2'd1: begin
                w_lane_byte    = m_rdata[15:8];
                w_merged[15:8] = r_bdata;
            end
            2'd2: begin
                w_lane_byte     = m_rdata[23:16];
                w_merged[23:16] = r_bdata;
            end
            2'd3: begin
                w_lane_byte     = m_rdata[31:24];
                w_merged[31:24] = r_bdata;
            end
            default: begin
                w_lane_byte = m_rdata[7:0];
            end
        endcase
        w_load = r_byte
               ? {{24{r_sext & w_lane_byte[7]}}, w_lane_byte}
               : m_rdata;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_we      <= 1'b0;
            r_byte    <= 1'b0;
            r_sext    <= 1'b0;
            r_lane    <= 2'd0;
            r_bdata   <= 8'h00;
            r_madr    <= '0;
            r_mwdata  <= '0;
            r_c_rdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_we    <= w_req_we;
                        r_byte  <= !w_sel_l && c_byte;
                        r_sext  <= c_sext;
                        r_lane  <= c_adr[1:0];
                        r_bdata <= c_wdata[7:0];
                        r_madr  <= w_req_adr[ADDR_W+1:2];
                        if (w_req_we && !w_rmw) begin
                            r_mwdata <= w_req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we && !w_own_l) begin
                        r_c_rdata <= w_load;
                    end
                end
                RMW_RD: begin
                    // m_wdata doubles as the merge buffer for RMW_WR.
                    r_mwdata <= w_merged;
                end
                default: begin
                end
            endcase
        end
    end

    assign m_adr    = r_madr;
    assign m_wdata  = r_mwdata;
    assign m_we     = w_m_we && !Reset;
    assign busy     = (r_state != IDLE);
    assign c_ack    = (r_state == RESP) && !w_own_l && !Reset;
    assign c_rdata  = r_c_rdata;
    assign w_unused = ^{w_req_adr[31:ADDR_W+2], w_req_adr[1:0]};

endmodule
